// File: rtl/axi2mem_pkg.sv
// axi2mem_pkg: shared burst encodings, width defaults and captured-AW attributes
package axi2mem_pkg;

    localparam int ID_WIDTH_DEF   = 6;
    localparam int ADDR_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    // Burst shape captured on the AW handshake; address and ID are kept
    // separately because their widths are module parameters.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } aw_attr_t;

    // Memory port is 32 bits wide, so wider beats are narrowed to 4 bytes.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return size > 3'd2 ? 3'd2 : size;
    endfunction

endpackage

// File: rtl/axi2mem_addr_gen.sv
// axi2mem_addr_gen: combinational next-beat address for FIXED, INCR and WRAP bursts
module axi2mem_addr_gen import axi2mem_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [2:0]            size_eff;
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_len;
    logic [ADDR_WIDTH-1:0] wrap_base;
    logic                  wrap_ok;

    // Align, step by one beat, and fold back to the wrap boundary for legal WRAP lengths;
    // illegal WRAP lengths and the reserved encoding fall through to INCR.
    always_comb begin
        size_eff    = clamp_size(size_i);
        bytes       = ADDR_WIDTH'(1) << size_eff;
        aligned     = addr_i & ~(bytes - ADDR_WIDTH'(1));
        incr        = aligned + bytes;
        wrap_len    = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_eff;
        wrap_base   = addr_i & ~(wrap_len - ADDR_WIDTH'(1));
        wrap_ok     = burst_i == BURST_WRAP &&
                      (len_i == 8'd1 || len_i == 8'd3 || len_i == 8'd7 || len_i == 8'd15);
        next_addr_o = burst_i == BURST_FIXED ? addr_i :
                      (wrap_ok && incr == wrap_base + wrap_len) ? wrap_base : incr;
    end

endmodule

// File: rtl/axi2mem_wr_cmd_unpack.sv
// axi2mem_wr_cmd_unpack: splits an AXI write burst into per-beat TCDM write commands
module axi2mem_wr_cmd_unpack import axi2mem_pkg::*; #(
    parameter int ID_WIDTH   = ID_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [2:0]            aw_size_i,
    input  logic [1:0]            aw_burst_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    output logic                  trans_req_o,
    input  logic                  trans_gnt_i,
    output logic [ADDR_WIDTH-1:0] trans_add_o,
    output logic [ID_WIDTH-1:0]   trans_id_o,
    output logic                  trans_last_o,
    output logic                  busy_o
);

    state_e                state_q, state_d;
    aw_attr_t              attr_q, attr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  beat_done;
    logic                  aw_hs;

    axi2mem_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i     (addr_q),
        .size_i     (attr_q.size),
        .len_i      (attr_q.len),
        .burst_i    (attr_q.burst),
        .next_addr_o(next_addr)
    );

    assign busy_o       = state_q == ST_BURST;
    assign trans_req_o  = busy_o;
    assign trans_last_o = busy_o && cnt_q == 8'd0;
    assign trans_add_o  = addr_q;
    assign trans_id_o   = id_q;
    assign beat_done    = trans_req_o && trans_gnt_i;
    // A new burst may be accepted in the same cycle the last beat is granted.
    assign aw_ready_o   = !busy_o || (trans_last_o && beat_done);
    assign aw_hs        = aw_valid_i && aw_ready_o;

    // Next state: load a new burst on handshake, otherwise advance one beat per grant.
    always_comb begin
        state_d = state_q;
        attr_d  = attr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        id_d    = id_q;
        if (aw_hs) begin
            state_d = ST_BURST;
            attr_d  = '{len: aw_len_i, size: aw_size_i, burst: aw_burst_i};
            cnt_d   = aw_len_i;
            addr_d  = aw_addr_i;
            id_d    = aw_id_i;
        end else if (beat_done) begin
            if (trans_last_o) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d  = cnt_q - 8'd1;
                addr_d = next_addr;
            end
        end
    end

    // State and burst registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            attr_q  <= '{len: 8'd0, size: 3'd0, burst: BURST_FIXED};
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            attr_q  <= attr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_axi2mem_wr_cmd_unpack.sv
// tb_axi2mem_wr_cmd_unpack: directed and randomized checks of the write-command unpacker
module tb_axi2mem_wr_cmd_unpack;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid_i = 1'b0;
    logic        aw_ready_o;
    logic [31:0] aw_addr_i = '0;
    logic [7:0]  aw_len_i = '0;
    logic [2:0]  aw_size_i = '0;
    logic [1:0]  aw_burst_i = '0;
    logic [5:0]  aw_id_i = '0;
    logic        trans_req_o;
    logic        trans_gnt_i = 1'b0;
    logic [31:0] trans_add_o;
    logic [5:0]  trans_id_o;
    logic        trans_last_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_addr[$];
    logic        obs_last[$];
    logic [5:0]  obs_id[$];
    int          unstable;
    int          first_lat;
    bit          timed_out;

    always #5 clk_i = ~clk_i;

    axi2mem_wr_cmd_unpack #(.ID_WIDTH(6), .ADDR_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .aw_valid_i  (aw_valid_i),
        .aw_ready_o  (aw_ready_o),
        .aw_addr_i   (aw_addr_i),
        .aw_len_i    (aw_len_i),
        .aw_size_i   (aw_size_i),
        .aw_burst_i  (aw_burst_i),
        .aw_id_i     (aw_id_i),
        .trans_req_o (trans_req_o),
        .trans_gnt_i (trans_gnt_i),
        .trans_add_o (trans_add_o),
        .trans_id_o  (trans_id_o),
        .trans_last_o(trans_last_o),
        .busy_o      (busy_o)
    );

    // Reference: beat i address from the burst rules, as offset arithmetic on the start address.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int l, input int s,
                                               input int b, input int i);
        longint unsigned bytes, al, wl, base, off;
        bit wrap;
        bytes = 64'd1 << (s > 2 ? 2 : s);
        wrap  = b == 2 && (l == 1 || l == 3 || l == 7 || l == 15);
        if (b == 0 || i == 0) return a;
        al  = ({32'd0, a} / bytes) * bytes;
        off = longint'(i) * bytes;
        if (!wrap) return al[31:0] + off[31:0];
        wl   = bytes * longint'(l + 1);
        base = (al / wl) * wl;
        off  = base + (al - base + off) % wl;
        return off[31:0];
    endfunction

    // Issue one AW and collect granted beats; gmode 0 = always grant, 1 = toggle, 2 = random.
    task automatic do_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [5:0] id, input int gmode);
        int n;
        bit tog, holding, done;
        logic [31:0] h_addr;
        logic        h_last;
        logic [5:0]  h_id;
        obs_addr.delete();
        obs_last.delete();
        obs_id.delete();
        unstable = 0; first_lat = -1; timed_out = 0;
        tog = 1; holding = 0; done = 0;
        h_addr = '0; h_last = 0; h_id = '0;
        @(negedge clk_i);
        aw_valid_i = 1; aw_addr_i = a; aw_len_i = l; aw_size_i = s; aw_burst_i = b; aw_id_i = id;
        trans_gnt_i = 0;
        n = 0;
        while (!aw_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!aw_ready_o) timed_out = 1;
        @(negedge clk_i);
        aw_valid_i = 0;
        n = 0;
        while (!done && n < 600) begin
            if (trans_req_o) begin
                if (first_lat < 0) first_lat = n;
                if (holding && (trans_add_o !== h_addr || trans_last_o !== h_last || trans_id_o !== h_id))
                    unstable++;
                if (gmode == 0) trans_gnt_i = 1;
                else if (gmode == 1) begin
                    trans_gnt_i = tog;
                    tog = !tog;
                end else trans_gnt_i = ($urandom_range(0, 3) != 0);
                if (trans_gnt_i) begin
                    obs_addr.push_back(trans_add_o);
                    obs_last.push_back(trans_last_o);
                    obs_id.push_back(trans_id_o);
                    holding = 0;
                    done = trans_last_o;
                end else begin
                    holding = 1;
                    h_addr = trans_add_o; h_last = trans_last_o; h_id = trans_id_o;
                end
            end
            @(negedge clk_i);
            n++;
        end
        if (!done) timed_out = 1;
        trans_gnt_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        #1;
        checks++;
        if ({aw_ready_o, trans_req_o, trans_last_o, busy_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got ready/req/last/busy=%b expected 1000",
                     {aw_ready_o, trans_req_o, trans_last_o, busy_o});
        end
        checks++;
        if (trans_add_o !== 32'd0 || trans_id_o !== 6'd0) begin
            errors++;
            $display("FAIL reset_data got add=%h id=%h expected 0/0", trans_add_o, trans_id_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    task automatic test_incr();
        logic [31:0] ea[4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        do_burst(32'h1000, 8'd3, 3'd2, 2'b01, 6'd5, 0);
        checks++;
        if (timed_out || obs_addr.size() != 4 || first_lat != 0) begin
            errors++;
            $display("FAIL incr_count got beats=%0d lat=%0d timeout=%0d expected 4/0/0",
                     obs_addr.size(), first_lat, timed_out);
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== ea[i] || obs_last[i] !== (i == 3) || obs_id[i] !== 6'd5) begin
                errors++;
                $display("FAIL incr_beat%0d got add=%h last=%b id=%0d expected %h/%b/5",
                         i, obs_addr[i], obs_last[i], obs_id[i], ea[i], i == 3);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea[4] = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
        do_burst(32'h2008, 8'd3, 3'd2, 2'b10, 6'd9, 0);
        checks++;
        if (timed_out || obs_addr.size() != 4) begin
            errors++;
            $display("FAIL wrap_count got beats=%0d timeout=%0d expected 4/0", obs_addr.size(), timed_out);
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== ea[i] || obs_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d got add=%h last=%b expected %h/%b",
                         i, obs_addr[i], obs_last[i], ea[i], i == 3);
            end
        end
    endtask

    task automatic test_fixed_gnt_toggle();
        do_burst(32'h3002, 8'd2, 3'd1, 2'b00, 6'd3, 1);
        checks++;
        if (timed_out || obs_addr.size() != 3 || unstable != 0) begin
            errors++;
            $display("FAIL fixed_count got beats=%0d unstable=%0d timeout=%0d expected 3/0/0",
                     obs_addr.size(), unstable, timed_out);
        end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            checks++;
            if (obs_addr[i] !== 32'h3002 || obs_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL fixed_beat%0d got add=%h last=%b expected 3002/%b",
                         i, obs_addr[i], obs_last[i], i == 2);
            end
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] ea[2] = '{32'h1001, 32'h1004};
        do_burst(32'h1001, 8'd1, 3'd2, 2'b01, 6'd1, 0);
        checks++;
        if (timed_out || obs_addr.size() != 2) begin
            errors++;
            $display("FAIL unal_count got beats=%0d expected 2", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            checks++;
            if (obs_addr[i] !== ea[i] || obs_last[i] !== (i == 1)) begin
                errors++;
                $display("FAIL unal_beat%0d got add=%h last=%b expected %h/%b",
                         i, obs_addr[i], obs_last[i], ea[i], i == 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        aw_valid_i = 1; aw_addr_i = 32'h5000; aw_len_i = 0; aw_size_i = 2; aw_burst_i = 2'b01; aw_id_i = 6'd1;
        trans_gnt_i = 1;
        @(negedge clk_i);
        aw_addr_i = 32'h6000; aw_id_i = 6'd2;
        #1;
        checks++;
        if ({trans_req_o, trans_last_o, aw_ready_o} !== 3'b111 || trans_add_o !== 32'h5000) begin
            errors++;
            $display("FAIL b2b_first got req/last/ready=%b add=%h expected 111/5000",
                     {trans_req_o, trans_last_o, aw_ready_o}, trans_add_o);
        end
        @(negedge clk_i);
        aw_valid_i = 0;
        #1;
        checks++;
        if ({trans_req_o, trans_last_o} !== 2'b11 || trans_add_o !== 32'h6000 || trans_id_o !== 6'd2) begin
            errors++;
            $display("FAIL b2b_second got req/last=%b add=%h id=%0d expected 11/6000/2",
                     {trans_req_o, trans_last_o}, trans_add_o, trans_id_o);
        end
        @(negedge clk_i);
        trans_gnt_i = 0;
        checks++;
        if (trans_req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got req=%b busy=%b expected 0/0", trans_req_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        @(negedge clk_i);
        aw_valid_i = 1; aw_addr_i = 32'h4000; aw_len_i = 7; aw_size_i = 2; aw_burst_i = 2'b01; aw_id_i = 6'd7;
        trans_gnt_i = 1;
        @(negedge clk_i);
        aw_valid_i = 0;
        @(negedge clk_i);
        checks++;
        if (trans_req_o !== 1'b1 || trans_add_o !== 32'h4004) begin
            errors++;
            $display("FAIL rst_beat2 got req=%b add=%h expected 1/4004", trans_req_o, trans_add_o);
        end
        rst_ni = 0;
        #1;
        checks++;
        if ({trans_req_o, busy_o, aw_ready_o, trans_last_o} !== 4'b0010 || trans_add_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_abandon got req/busy/ready/last=%b add=%h expected 0010/0",
                     {trans_req_o, busy_o, aw_ready_o, trans_last_o}, trans_add_o);
        end
        @(negedge clk_i);
        rst_ni = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (trans_req_o) seen++;
        end
        trans_gnt_i = 0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_no_beats got %0d req cycles expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, e;
        int l, s, b;
        logic [5:0] id;
        for (int k = 0; k < 40; k++) begin
            a  = $urandom;
            l  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            s  = $urandom_range(0, 7);
            b  = $urandom_range(0, 3);
            id = 6'($urandom);
            do_burst(a, 8'(l), 3'(s), 2'(b), id, 2);
            checks++;
            if (timed_out || obs_addr.size() != l + 1 || unstable != 0) begin
                errors++;
                $display("FAIL rnd%0d_count got beats=%0d unstable=%0d timeout=%0d expected %0d/0/0",
                         k, obs_addr.size(), unstable, timed_out, l + 1);
            end
            for (int i = 0; i < obs_addr.size() && i <= l; i++) begin
                e = model_addr(a, l, s, b, i);
                checks++;
                if (obs_addr[i] !== e || obs_last[i] !== (i == l) || obs_id[i] !== id) begin
                    errors++;
                    $display("FAIL rnd%0d_beat%0d got add=%h last=%b id=%0d expected %h/%b/%0d",
                             k, i, obs_addr[i], obs_last[i], obs_id[i], e, i == l, id);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_gnt_toggle();
        test_unaligned();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
